mem_uart_streamer: RTL

- Parametrised send engine that streams a run of entries from a synchronous-read ROM/RAM to the UART transmitter.
- Inputs are a start address and a length; output format is raw bytes or ASCII hex with separators and line breaks.
- Sits between the memory units and the UART module and replaces the fixed-length character sender.
- Generalises that sender with configurable width/depth, start/length control, address wrap, hex formatting, back-pressure handling and abort.

---
 rtl/mem_uart_streamer.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_uart_streamer.sv
// -----------------------------------------------------------------------------
// mem_uart_streamer
//
// Streams a run of entries from a synchronous-read ROM/RAM to a UART transmit
// FIFO. Each entry is sent either as one raw byte or as two ASCII hex digits
// and a space. Hex output breaks lines every LINE_LEN entries, and every
// transfer ends with a single CR LF. The engine honours UART back-pressure and
// supports abort.
//
// Ports:
//   clock, reset     system clock; synchronous active-high reset
//   start            one-cycle pulse that begins a transfer (ignored while busy)
//   abort            level; ends the current transfer without a done pulse
//   hex_mode         0 = raw bytes, 1 = ASCII hex
//   start_addr       first entry (values >= DEPTH start from 0)
//   length           number of entries (values > DEPTH are clamped to DEPTH)
//   mem_addr         registered memory address
//   mem_data         memory read data, valid one cycle after mem_addr
//   tx_full          UART FIFO full
//   write_to_uart    one-cycle write strobe, with tx_data alongside
//   busy             transfer in progress
//   done             one-cycle pulse on normal completion
//   sent_count       entries fully emitted in the current/last transfer
//
// DATA_WIDTH must lie in 1..8.
// -----------------------------------------------------------------------------
module mem_uart_streamer #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 7,
  parameter int DEPTH      = 50,
  parameter int LINE_LEN   = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  hex_mode,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  tx_full,
  output logic                  write_to_uart,
  output logic [7:0]            tx_data,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   sent_count
);

  localparam int LW = $clog2(LINE_LEN + 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_L    = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [LW-1:0]         LINE_LEN_L = LW'(LINE_LEN);

  typedef enum logic [3:0] {
    IDLE, FETCH, CAPTURE, EMIT_RAW, EMIT_HI, EMIT_LO,
    EMIT_SP, EMIT_CR, EMIT_LF, GAP, FINISH
  } state_e;

  state_e                state_q, state_d;
  state_e                ret_q, ret_d;       // state to enter after GAP
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic                  hex_q, hex_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [ADDR_WIDTH:0]   sent_q, sent_d;
  logic [LW-1:0]         line_q, line_d;     // entries on the current hex line
  logic                  write_q, write_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    if (nib < 4'd10) return {4'h3, nib};
    else             return 8'h37 + {4'h0, nib};
  endfunction

  // Shared decode used by both combinational processes.
  logic                  emit_state, emit_fire, entry_end;
  logic                  last_entry, line_full, line_wrap;
  logic [ADDR_WIDTH:0]   sent_inc;
  logic [LW-1:0]         line_inc;
  logic [ADDR_WIDTH-1:0] start_addr_ok;
  logic [ADDR_WIDTH:0]   length_ok;
  logic [7:0]            word_ext;

  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first so no path leaves it unassigned, which would infer a latch.
    word_ext                 = '0;
    word_ext[DATA_WIDTH-1:0] = word_q;
  end

  assign emit_state = (state_q == EMIT_RAW) || (state_q == EMIT_HI) ||
                      (state_q == EMIT_LO)  || (state_q == EMIT_SP) ||
                      (state_q == EMIT_CR)  || (state_q == EMIT_LF);
  // Abort wins over a pending write.
  assign emit_fire  = emit_state && !tx_full && !abort;
  assign entry_end  = emit_fire && ((state_q == EMIT_RAW) || (state_q == EMIT_SP));
  assign sent_inc   = sent_q + 1'b1;
  assign last_entry = (sent_inc == len_q);
  assign line_inc   = line_q + 1'b1;
  assign line_wrap  = (line_inc == LINE_LEN_L);
  assign line_full  = hex_q && line_wrap;

  assign start_addr_ok = ({1'b0, start_addr} >= DEPTH_L) ? '0 : start_addr;
  assign length_ok     = (length > DEPTH_L) ? DEPTH_L : length;

  // State register and all datapath/output flops.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge value regardless of statement order.
    if (reset) begin
      state_q    <= IDLE;
      ret_q      <= IDLE;
      mem_addr_q <= '0;
      len_q      <= '0;
      hex_q      <= 1'b0;
      word_q     <= '0;
      sent_q     <= '0;
      line_q     <= '0;
      write_q    <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      mem_addr_q <= mem_addr_d;
      len_q      <= len_d;
      hex_q      <= hex_d;
      word_q     <= word_d;
      sent_q     <= sent_d;
      line_q     <= line_d;
      write_q    <= write_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    if (state_q != IDLE && abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:     if (start) state_d = (length_ok == '0) ? FINISH : FETCH;
        FETCH:    state_d = CAPTURE;
        CAPTURE:  state_d = hex_q ? EMIT_HI : EMIT_RAW;
        EMIT_RAW,
        EMIT_SP:  if (!tx_full) begin
                    state_d = GAP;
                    // A final line boundary produces only one CR LF.
                    ret_d   = (last_entry || line_full) ? EMIT_CR : FETCH;
                  end
        EMIT_HI:  if (!tx_full) begin state_d = GAP; ret_d = EMIT_LO; end
        EMIT_LO:  if (!tx_full) begin state_d = GAP; ret_d = EMIT_SP; end
        EMIT_CR:  if (!tx_full) begin state_d = GAP; ret_d = EMIT_LF; end
        EMIT_LF:  if (!tx_full) begin
                    state_d = GAP;
                    ret_d   = (sent_q == len_q) ? FINISH : FETCH;
                  end
        GAP:      state_d = ret_q;
        FINISH:   state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  // Output and datapath logic.
  always_comb begin
    mem_addr_d = mem_addr_q;
    len_d      = len_q;
    hex_d      = hex_q;
    word_d     = word_q;
    sent_d     = sent_q;
    line_d     = line_q;
    write_d    = 1'b0;
    tx_data_d  = tx_data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: if (start) begin
        mem_addr_d = start_addr_ok;
        len_d      = length_ok;
        hex_d      = hex_mode;
        sent_d     = '0;
        line_d     = '0;
        busy_d     = 1'b1;
      end
      CAPTURE: word_d = mem_data;
      FINISH: begin
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: ;
    endcase

    if (emit_fire) begin
      write_d = 1'b1;
      case (state_q)
        EMIT_RAW: tx_data_d = word_ext;
        EMIT_HI:  tx_data_d = hex_char(word_ext[7:4]);
        EMIT_LO:  tx_data_d = hex_char(word_ext[3:0]);
        EMIT_SP:  tx_data_d = 8'h20;
        EMIT_CR:  tx_data_d = 8'h0D;
        default:  tx_data_d = 8'h0A;
      endcase
    end

    if (entry_end) begin
      sent_d     = sent_inc;
      mem_addr_d = (mem_addr_q == LAST_ADDR) ? '0 : mem_addr_q + 1'b1;
      line_d     = line_wrap ? '0 : line_inc;
    end

    if (state_q != IDLE && abort) begin
      busy_d = 1'b0;
      done_d = 1'b0;
    end
  end

  assign mem_addr      = mem_addr_q;
  assign write_to_uart = write_q;
  assign tx_data       = tx_data_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign sent_count    = sent_q;

endmodule
